// File: rtl/image_stream_pkg.sv
// Shared types and constants for the image stream reader: FSM states, pixel
// operation codes and RGB channel layout within a 24-bit pixel.
package image_stream_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StHsync,
        StData,
        StDone
    } state_e;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_THRESH = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;
    localparam logic [1:0] MODE_BRIGHT = 2'd3;

    localparam int unsigned R_LSB      = 0;
    localparam int unsigned G_LSB      = 8;
    localparam int unsigned B_LSB      = 16;
    localparam int unsigned PIXEL_BITS = 24;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hff : s[7:0];
    endfunction

endpackage

// File: rtl/image_stream_reader_pixel_op.sv
// Combinational per-pixel operation: pass, luminance-sum threshold, invert or
// saturating brighten, applied to one packed RGB pixel.
module pixel_op
    import image_stream_pkg::*;
(
    input  logic [1:0]            mode_i,
    input  logic [7:0]            threshold_i,
    input  logic [PIXEL_BITS-1:0] pixel_i,
    output logic [PIXEL_BITS-1:0] pixel_o
);

    logic [7:0] r, g, b;
    logic [9:0] sum;
    logic [9:0] limit;

    always_comb begin
        r     = pixel_i[R_LSB +: 8];
        g     = pixel_i[G_LSB +: 8];
        b     = pixel_i[B_LSB +: 8];
        sum   = {2'b00, r} + {2'b00, g} + {2'b00, b};
        // Compare R+G+B against 3*threshold rather than dividing the sum.
        limit = {2'b00, threshold_i} + {2'b00, threshold_i} + {2'b00, threshold_i};

        pixel_o = pixel_i;
        unique case (mode_i)
            MODE_PASS: pixel_o = pixel_i;
            MODE_THRESH: pixel_o = (sum > limit) ? {PIXEL_BITS{1'b1}} : '0;
            MODE_INVERT: pixel_o = ~pixel_i;
            MODE_BRIGHT: begin
                pixel_o[R_LSB +: 8] = sat_add8(r, threshold_i);
                pixel_o[G_LSB +: 8] = sat_add8(g, threshold_i);
                pixel_o[B_LSB +: 8] = sat_add8(b, threshold_i);
            end
            default: pixel_o = pixel_i;
        endcase
    end

endmodule

// File: rtl/image_stream_reader.sv
// Frame source: reads a bottom-up RGB frame from pixel RAM, applies the latched
// pixel operation and streams beats with sync pulses and valid/ready flow control.
module image_stream_reader
    import image_stream_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH    = 768,
    parameter int unsigned IMAGE_HEIGHT   = 512,
    parameter int unsigned PIXELS_PER_CLK = 2,
    parameter int unsigned START_DELAY    = 100,
    parameter int unsigned HSYNC_DELAY    = 160,
    parameter int unsigned ADDR_WIDTH     = 20
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [1:0]                           mode_i,
    input  logic [7:0]                           threshold_i,
    output logic                                 mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    input  logic [PIXEL_BITS*PIXELS_PER_CLK-1:0] mem_rd_data_i,
    output logic [PIXEL_BITS*PIXELS_PER_CLK-1:0] out_data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic                                 vertical_pulse_o,
    output logic                                 horizontal_pulse_o,
    output logic                                 done_flag_o,
    output logic                                 busy_o
);

    localparam int unsigned DataW  = PIXEL_BITS * PIXELS_PER_CLK;
    localparam int unsigned Beats  = IMAGE_WIDTH / PIXELS_PER_CLK;
    localparam int unsigned BeatW  = $clog2(Beats + 1);
    localparam int unsigned RowW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned DlyMax = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;

    localparam logic [BeatW-1:0]      BeatsC    = BeatW'(Beats);
    localparam logic [BeatW-1:0]      LastBeat  = BeatW'(Beats - 1);
    localparam logic [RowW-1:0]       LastRow   = RowW'(IMAGE_HEIGHT - 1);
    localparam logic [DlyW-1:0]       VsyncLast = DlyW'(START_DELAY - 1);
    localparam logic [DlyW-1:0]       HsyncLast = DlyW'(HSYNC_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] RowStride = ADDR_WIDTH'(Beats);
    localparam logic [ADDR_WIDTH-1:0] TopBase   = ADDR_WIDTH'((IMAGE_HEIGHT - 1) * Beats);

    state_e                state_q, state_d;
    logic [DlyW-1:0]       dly_q, dly_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [BeatW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [BeatW-1:0]      out_cnt_q, out_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            mode_q, mode_d;
    logic [7:0]            thr_q, thr_d;
    logic                  rd_q;
    logic [DataW-1:0]      slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            cnt_after_pop;
    logic                  vpulse_q, hpulse_q, done_q, busy_q;

    logic                  pop;
    logic                  rd_en;
    logic [2:0]            occ;
    logic [DataW-1:0]      op_data;

    for (genvar k = 0; k < PIXELS_PER_CLK; k++) begin : g_pix
        pixel_op u_pixel_op (
            .mode_i      (mode_q),
            .threshold_i (thr_q),
            .pixel_i     (mem_rd_data_i[k*PIXEL_BITS +: PIXEL_BITS]),
            .pixel_o     (op_data[k*PIXEL_BITS +: PIXEL_BITS])
        );
    end

    assign out_valid_o        = (cnt_q != 2'd0);
    assign out_data_o         = slot0_q;
    assign pop                = out_valid_o & out_ready_i;
    assign vertical_pulse_o   = vpulse_q;
    assign horizontal_pulse_o = hpulse_q;
    assign done_flag_o        = done_q;
    assign busy_o             = busy_q;

    // A beat leaving this cycle frees its slot, which keeps the stream at 1 beat/cycle.
    assign occ         = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, rd_q};
    assign rd_en       = (state_q == StData) && (rd_cnt_q != BeatsC) && (occ < 3'd2);
    assign mem_rd_en_o = rd_en;
    assign mem_addr_o  = rd_en ? (base_q + ADDR_WIDTH'(rd_cnt_q)) : '0;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        row_d     = row_q;
        rd_cnt_d  = rd_en ? (rd_cnt_q + 1'b1) : rd_cnt_q;
        out_cnt_d = out_cnt_q;
        base_d    = base_q;
        mode_d    = mode_q;
        thr_d     = thr_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StVsync;
                    dly_d   = '0;
                    row_d   = '0;
                    base_d  = TopBase;
                    mode_d  = mode_i;
                    thr_d   = threshold_i;
                end
            end
            StVsync: begin
                if (dly_q == VsyncLast) begin
                    state_d = StHsync;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StHsync: begin
                if (dly_q == HsyncLast) begin
                    state_d   = StData;
                    dly_d     = '0;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StData: begin
                if (pop) begin
                    if (out_cnt_q == LastBeat) begin
                        out_cnt_d = '0;
                        rd_cnt_d  = '0;
                        if (row_q == LastRow) begin
                            state_d = StDone;
                        end else begin
                            state_d = StHsync;
                            row_d   = row_q + 1'b1;
                            base_d  = base_q - RowStride;
                        end
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        cnt_after_pop = cnt_q - {1'b0, pop};
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (rd_q) begin
            if (cnt_after_pop == 2'd0) begin
                slot0_d = op_data;
            end else begin
                slot1_d = op_data;
            end
        end
        cnt_d = cnt_after_pop + {1'b0, rd_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            dly_q     <= '0;
            row_q     <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            base_q    <= '0;
            mode_q    <= MODE_PASS;
            thr_q     <= '0;
            rd_q      <= 1'b0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            cnt_q     <= '0;
            vpulse_q  <= 1'b0;
            hpulse_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            row_q     <= row_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            base_q    <= base_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            rd_q      <= rd_en;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            cnt_q     <= cnt_d;
            vpulse_q  <= (state_d == StVsync);
            hpulse_q  <= (state_d == StData);
            done_q    <= (state_d == StDone);
            busy_q    <= (state_d != StIdle);
        end
    end

endmodule
